// File: rtl/md_issue_ctrl_if.sv
// E-stage to multiply/divide issue controller bundle.
// master = pipeline side, slave = issue controller.
interface md_issue_ctrl_if;
  logic        op_valid;
  logic [3:0]  op;
  logic        op_u;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        stall;
  logic        md_start;
  logic [2:0]  md_sel;
  logic        md_u;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_write;
  logic [1:0]  md_load;
  logic        busy;
  logic        done;

  modport master (
    output op_valid, op, op_u, rs_val, rt_val, flush,
    input  stall, md_start, md_sel, md_u, md_a, md_b,
    input  md_write, md_load, busy, done
  );

  modport slave (
    input  op_valid, op, op_u, rs_val, rt_val, flush,
    output stall, md_start, md_sel, md_u, md_a, md_b,
    output md_write, md_load, busy, done
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue controller for the HI/LO multiply/divide unit: accepts,
// stalls and times MD-class instructions presented in E-stage.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input logic          clk,
    input logic          reset,
    md_issue_ctrl_if.slave io
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [3:0] MulCnt = 4'(MUL_LAT);
    localparam logic [3:0] DivCnt = 4'(DIV_LAT);

    state_e      state_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q;
    logic        start_q;
    logic [2:0]  sel_q;
    logic        u_q;
    logic [31:0] a_q, b_q;
    logic [1:0]  write_q;

    logic [3:0]  op_c;
    logic        is_arith, is_move, is_read, is_md;
    logic        busy, accept;

    // Opcodes 9-15 behave exactly like "none".
    assign op_c     = (io.op > 4'd8) ? 4'd0 : io.op;
    assign is_arith = (op_c >= 4'd1) && (op_c <= 4'd4);
    assign is_move  = (op_c == 4'd5) || (op_c == 4'd6);
    assign is_read  = (op_c == 4'd7) || (op_c == 4'd8);
    assign is_md    = is_arith || is_move || is_read;

    assign busy   = (state_q == BUSY);
    assign accept = io.op_valid && is_md && !busy && !io.flush;

    assign io.stall    = io.op_valid && is_md && busy && !io.flush;
    assign io.busy     = busy;
    assign io.done     = done_q;
    assign io.md_start = start_q;
    assign io.md_sel   = sel_q;
    assign io.md_u     = u_q;
    assign io.md_a     = a_q;
    assign io.md_b     = b_q;
    assign io.md_write = write_q;

    always_comb begin
        io.md_load = 2'b00;
        if (accept && is_read) begin
            io.md_load = (op_c == 4'd7) ? 2'b01 : 2'b10;
        end
    end

    // Accept only happens with cnt at zero, so no reload mid-count.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && is_arith) begin
            cnt_d = (op_c == 4'd2) ? DivCnt : MulCnt;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            sel_q   <= 3'd0;
            u_q     <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            write_q <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= (cnt_d != 4'd0) ? BUSY : IDLE;
            done_q  <= (cnt_q == 4'd1);
            start_q <= accept && is_arith;
            sel_q   <= (accept && is_arith) ? op_c[2:0] : 3'd0;
            write_q <= 2'b00;
            if (accept && is_arith) begin
                u_q <= io.op_u;
                a_q <= io.rs_val;
                b_q <= io.rt_val;
            end
            if (accept && is_move) begin
                a_q     <= io.rs_val;
                write_q <= (op_c == 4'd5) ? 2'b01 : 2'b10;
            end
        end
    end

endmodule
